// File: rtl/video_pkg.sv
// Timing-set types and default raster sets (50 Hz PAL, 60 Hz NTSC) shared by the raster generator.
package video_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] total;
    logic [TW-1:0] sync_beg;
    logic [TW-1:0] sync_end;
    logic [TW-1:0] act_beg;
    logic [TW-1:0] act_end;
    logic [TW-1:0] int_pos;
    logic          pol;
  } axis_timing_t;

  typedef axis_timing_t h_timing_t;
  typedef axis_timing_t v_timing_t;

  localparam h_timing_t PAL_H = '{total: 16'd447, sync_beg: 16'd11, sync_end: 16'd43,
                                  act_beg: 16'd88, act_end: 16'd447, int_pos: 16'd0, pol: 1'b0};
  localparam v_timing_t PAL_V = '{total: 16'd319, sync_beg: 16'd8, sync_end: 16'd11,
                                  act_beg: 16'd32, act_end: 16'd319, int_pos: 16'd0, pol: 1'b0};
  localparam h_timing_t NTSC_H = PAL_H;
  localparam v_timing_t NTSC_V = '{total: 16'd261, sync_beg: 16'd4, sync_end: 16'd7,
                                   act_beg: 16'd22, act_end: 16'd261, int_pos: 16'd0, pol: 1'b0};

  function automatic axis_timing_t pack_timing(
    input logic [TW-1:0] total,
    input logic [TW-1:0] sync_beg,
    input logic [TW-1:0] sync_end,
    input logic [TW-1:0] act_beg,
    input logic [TW-1:0] act_end,
    input logic [TW-1:0] int_pos,
    input logic          pol
  );
    axis_timing_t t;
    t.total    = total;
    t.sync_beg = sync_beg;
    t.sync_end = sync_end;
    t.act_beg  = act_beg;
    t.act_end  = act_end;
    t.int_pos  = int_pos;
    t.pol      = pol;
    return t;
  endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis: position counter with wrap and overflow guard, plus half-open
// sync/active/interrupt decode against the committed timing set.
module video_axis_cnt
  import video_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  axis_timing_t tim,
  output logic [W-1:0] count,
  output logic         at_end,
  output logic         sync_win,
  output logic         sync_pol,
  output logic         act_win,
  output logic         int_match
);

  logic [TW-1:0] pos;

  assign pos = TW'(count);

  // >= so that a count beyond total snaps back to 0 on the next advance
  assign at_end = (pos >= tim.total);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (adv) begin
      count <= at_end ? '0 : count + W'(1);
    end
  end

  // beg >= end yields an empty window; there are no wrap-around windows
  assign sync_win  = (pos >= tim.sync_beg) && (pos < tim.sync_end);
  assign sync_pol  = tim.pol ? sync_win : ~sync_win;
  assign act_win   = (pos >= tim.act_beg) && (pos < tim.act_end);
  assign int_match = (pos == tim.int_pos);

endmodule

// File: rtl/video_raster_gen.sv
// Programmable raster generator: staged timing committed at the frame wrap, registered
// sync/blank/active/strobe outputs aligned with the delayed raster position.
module video_raster_gen
  import video_pkg::*;
#(
  parameter int HW      = 10,
  parameter int VW      = 10,
  parameter int FLASH_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [HW-1:0] cfg_h_total,
  input  logic [HW-1:0] cfg_h_sync_beg,
  input  logic [HW-1:0] cfg_h_sync_end,
  input  logic [HW-1:0] cfg_h_act_beg,
  input  logic [HW-1:0] cfg_h_act_end,
  input  logic [VW-1:0] cfg_v_total,
  input  logic [VW-1:0] cfg_v_sync_beg,
  input  logic [VW-1:0] cfg_v_sync_end,
  input  logic [VW-1:0] cfg_v_act_beg,
  input  logic [VW-1:0] cfg_v_act_end,
  input  logic [HW-1:0] cfg_int_h,
  input  logic [VW-1:0] cfg_int_v,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  input  logic          cfg_wr,
  output logic          cfg_pending,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          blank,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          int_start,
  output logic          frame,
  output logic          flash
);

  h_timing_t          h_stage, h_shadow;
  v_timing_t          v_stage, v_shadow;
  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               h_end, h_sync_win, h_sync_pol, h_act_win, h_int_match;
  logic               v_end, v_sync_win, v_sync_pol, v_act_win, v_int_match;
  logic               h_wrap_tick, frame_tick, int_hit;
  logic [FLASH_W-1:0] flash_cnt;

  assign h_wrap_tick = ce & h_end;
  assign frame_tick  = h_wrap_tick & v_end;
  assign int_hit     = ce & h_int_match & v_int_match;

  video_axis_cnt #(.W(HW)) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .adv       (ce),
    .tim       (h_shadow),
    .count     (h_cnt),
    .at_end    (h_end),
    .sync_win  (h_sync_win),
    .sync_pol  (h_sync_pol),
    .act_win   (h_act_win),
    .int_match (h_int_match)
  );

  video_axis_cnt #(.W(VW)) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .adv       (h_wrap_tick),
    .tim       (v_shadow),
    .count     (v_cnt),
    .at_end    (v_end),
    .sync_win  (v_sync_win),
    .sync_pol  (v_sync_pol),
    .act_win   (v_act_win),
    .int_match (v_int_match)
  );

  // Handshake: cfg_wr is a one-clk request that stages every cfg_* input and raises
  // cfg_pending; cfg_pending drops on the frame wrap tick that copies staging into the
  // shadow set. A cfg_wr on that wrap tick wins: it restages and stays pending a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_stage     <= PAL_H;
      v_stage     <= PAL_V;
      h_shadow    <= PAL_H;
      v_shadow    <= PAL_V;
      cfg_pending <= 1'b0;
    end else if (cfg_wr) begin
      h_stage     <= pack_timing(TW'(cfg_h_total), TW'(cfg_h_sync_beg), TW'(cfg_h_sync_end),
                                 TW'(cfg_h_act_beg), TW'(cfg_h_act_end), TW'(cfg_int_h), cfg_hpol);
      v_stage     <= pack_timing(TW'(cfg_v_total), TW'(cfg_v_sync_beg), TW'(cfg_v_sync_end),
                                 TW'(cfg_v_act_beg), TW'(cfg_v_act_end), TW'(cfg_int_v), cfg_vpol);
      cfg_pending <= 1'b1;
    end else if (frame_tick && cfg_pending) begin
      h_shadow    <= h_stage;
      v_shadow    <= v_stage;
      cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~cfg_hpol;
      vsync       <= ~cfg_vpol;
      csync       <= 1'b1;
      blank       <= 1'b1;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      int_start   <= 1'b0;
      flash_cnt   <= '0;
    end else begin
      hcount      <= h_cnt;
      vcount      <= v_cnt;
      hsync       <= h_sync_pol;
      vsync       <= v_sync_pol;
      csync       <= ~(h_sync_win ^ v_sync_win);
      blank       <= ~(h_act_win & v_act_win);
      active      <= h_act_win & v_act_win;
      line_start  <= h_wrap_tick;
      frame_start <= frame_tick;
      int_start   <= int_hit;
      if (frame_tick) flash_cnt <= flash_cnt + FLASH_W'(1);
    end
  end

  assign frame = flash_cnt[0];
  assign flash = flash_cnt[FLASH_W-1];

endmodule
